// File: rtl/vfma_pkg.sv
// Shared definitions for the vector FMA issue block.
//   VLEN          : operand/result width in bits
//   LAT_DEF       : default fixed FMA pipeline latency
//   TAG_W_DEF     : default request tag width
//   RQ_DEPTH_DEF  : default result queue depth
//   vfma_entry_t  : result queue entry {tag, data} at the default tag width
package vfma_pkg;

   localparam int VLEN         = 512;
   localparam int LAT_DEF      = 5;
   localparam int TAG_W_DEF    = 6;
   localparam int RQ_DEPTH_DEF = 8;

   typedef struct packed {
      logic [TAG_W_DEF-1:0] tag;
      logic [VLEN-1:0]      data;
   } vfma_entry_t;

endpackage

// File: rtl/vfma_result_fifo.sv
// Result queue for the vector FMA issue block.
// Power-of-two depth circular buffer with a registered head entry.
// Pop and push may happen together when full, because the slot being
// read is freed in the same edge. Pop is ignored when empty.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clr_i             : synchronous clear (flush), empties the queue
//   push_i, entry_i   : write request and entry
//   pop_i             : remove head entry
//   head_o            : current head entry (valid when !empty_o)
//   full_o, empty_o   : occupancy flags
//   count_o           : number of stored entries (0..DEPTH)
module vfma_result_fifo
   import vfma_pkg::*;
#(
   parameter int  DEPTH   = RQ_DEPTH_DEF,
   parameter type entry_t = vfma_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_i,
   input  logic                   push_i,
   input  entry_t                 entry_i,
   input  logic                   pop_i,
   output entry_t                 head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            do_push_s, do_pop_s;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy next state; pointers wrap naturally (power of two).
   always_comb begin
      do_push_s = push_i & (~full_o | pop_i);
      do_pop_s  = pop_i & ~empty_o;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(do_push_s);
         rd_ptr_d = rd_ptr_q + AW'(do_pop_s);
         cnt_d    = cnt_q + (AW + 1)'(do_push_s) - (AW + 1)'(do_pop_s);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push_s && !clr_i) begin
         mem_q[wr_ptr_q] <= entry_i;
      end
   end

endmodule

// File: rtl/vector_fma_issue.sv
// Vector FMA issue block: accepts tagged 3-operand requests, issues them
// to a fixed-latency FMA unit (no backpressure), tracks tags in a LAT-deep
// shift register aligned with the returning results, and queues results
// for in-order writeback.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid_i/req_ready_o       : request handshake
//   req_tag_i, req_src1..3_i      : request tag and operands a, b, c
//   flush_i                       : drop all in-flight and queued work
//   fma_valid_o, fma_src1..3_o    : registered issue to FMA unit
//   fma_valid_i, fma_result_i     : FMA result return (LAT after issue)
//   wb_valid_o/wb_ready_i         : writeback handshake
//   wb_tag_o, wb_data_o           : head result
//   err_o                         : sticky protocol error
// Optional build macro VFMA_ISSUE_PERF_EN adds perf_issued_o and
// perf_stall_o (32-bit wrapping counters).
module vector_fma_issue
   import vfma_pkg::*;
#(
   parameter int LAT      = LAT_DEF,
   parameter int TAG_W    = TAG_W_DEF,
   parameter int RQ_DEPTH = RQ_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [TAG_W-1:0] req_tag_i,
   input  logic [VLEN-1:0]  req_src1_i,
   input  logic [VLEN-1:0]  req_src2_i,
   input  logic [VLEN-1:0]  req_src3_i,
   input  logic             flush_i,
   output logic             fma_valid_o,
   output logic [VLEN-1:0]  fma_src1_o,
   output logic [VLEN-1:0]  fma_src2_o,
   output logic [VLEN-1:0]  fma_src3_o,
   input  logic             fma_valid_i,
   input  logic [VLEN-1:0]  fma_result_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [TAG_W-1:0] wb_tag_o,
   output logic [VLEN-1:0]  wb_data_o,
`ifdef VFMA_ISSUE_PERF_EN
   output logic [31:0]      perf_issued_o,
   output logic [31:0]      perf_stall_o,
`endif
   output logic             err_o
);

   localparam int CW = $clog2(RQ_DEPTH) + 1;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [VLEN-1:0]  data;
   } entry_t;

   logic             accept_s;
   logic             fma_valid_q;
   logic [TAG_W-1:0] issue_tag_q;
   logic [VLEN-1:0]  src1_q, src2_q, src3_q;

   logic [LAT-1:0]   slot_vld_q, slot_vld_d;
   logic [LAT-1:0]   slot_kill_q, slot_kill_d;
   logic [TAG_W-1:0] slot_tag_q [LAT];
   logic [TAG_W-1:0] slot_tag_d [LAT];

   logic             exit_vld_s, exit_kill_s;
   logic             push_s, pop_s, drop_s;
   entry_t           push_entry_s, head_s;
   logic             fifo_full_s, fifo_empty_s;
   logic [CW-1:0]    fifo_cnt_s;

   logic [CW-1:0]    used_q, used_d;
   logic             err_q, err_d;

   // used_q covers ops in flight plus queued results, so a free credit
   // guarantees a queue slot when the (unstoppable) result returns.
   assign req_ready_o = (used_q < CW'(RQ_DEPTH)) & ~flush_i & ~rst;
   assign accept_s    = req_valid_i & req_ready_o;

   assign fma_valid_o = fma_valid_q;
   assign fma_src1_o  = src1_q;
   assign fma_src2_o  = src2_q;
   assign fma_src3_o  = src3_q;

   // Issue strobe: exactly one cycle after each accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         fma_valid_q <= 1'b0;
      end else begin
         fma_valid_q <= accept_s;
      end
   end

   // Operand and tag capture at accept.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         issue_tag_q <= req_tag_i;
         src1_q      <= req_src1_i;
         src2_q      <= req_src2_i;
         src3_q      <= req_src3_i;
      end
   end

   // Tag pipe next state. The op on the issue strobe enters stage 0, so
   // stage LAT-1 holds it exactly when its result returns. A flush kills
   // every op in flight, including the one being issued this cycle.
   always_comb begin
      slot_vld_d[0]  = fma_valid_q;
      slot_kill_d[0] = flush_i;
      slot_tag_d[0]  = issue_tag_q;
      for (int i = 1; i < LAT; i++) begin
         slot_vld_d[i]  = slot_vld_q[i-1];
         slot_kill_d[i] = slot_kill_q[i-1] | flush_i;
         slot_tag_d[i]  = slot_tag_q[i-1];
      end
   end

   // Tag pipe valid/kill registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld_q  <= '0;
         slot_kill_q <= '0;
      end else begin
         slot_vld_q  <= slot_vld_d;
         slot_kill_q <= slot_kill_d;
      end
   end

   // Tag pipe tag registers; tags are qualified by the valid bits.
   always_ff @(posedge clk) begin
      slot_tag_q <= slot_tag_d;
   end

   assign exit_vld_s  = slot_vld_q[LAT-1];
   assign exit_kill_s = slot_kill_q[LAT-1];

   // Live result is queued; any other retiring slot just frees its credit.
   assign push_s            = exit_vld_s & ~exit_kill_s & fma_valid_i & ~flush_i;
   assign drop_s            = exit_vld_s & ~push_s;
   assign pop_s             = wb_valid_o & wb_ready_i & ~flush_i;
   assign push_entry_s.tag  = slot_tag_q[LAT-1];
   assign push_entry_s.data = fma_result_i;

   vfma_result_fifo #(
      .DEPTH   (RQ_DEPTH),
      .entry_t (entry_t)
   ) u_result_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush_i),
      .push_i  (push_s),
      .entry_i (push_entry_s),
      .pop_i   (pop_s),
      .head_o  (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_cnt_s)
   );

   assign wb_valid_o = ~fifo_empty_s;
   assign wb_tag_o   = head_s.tag;
   assign wb_data_o  = head_s.data;

   // Credit counter and sticky error next state. On flush the queue empties
   // and the retiring slot leaves, so what remains is the in-flight count.
   always_comb begin
      used_d = used_q;
      err_d  = err_q;
      if (flush_i) begin
         used_d = used_q - fifo_cnt_s - CW'(exit_vld_s);
      end else begin
         used_d = used_q + CW'(accept_s) - CW'(pop_s) - CW'(drop_s);
      end
      if ((fma_valid_i != exit_vld_s) || (push_s && fifo_full_s && !pop_s)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Credit counter and error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         used_q <= '0;
         err_q  <= 1'b0;
      end else begin
         used_q <= used_d;
         err_q  <= err_d;
      end
   end

   assign err_o = err_q;

`ifdef VFMA_ISSUE_PERF_EN
   logic [31:0] perf_issued_q, perf_stall_q;

   // Accept and stall counters, wrapping, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else begin
         perf_issued_q <= perf_issued_q + 32'(accept_s);
         perf_stall_q  <= perf_stall_q + 32'(req_valid_i & ~req_ready_o);
      end
   end

   assign perf_issued_o = perf_issued_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_fma_issue.sv
// Self-checking bench for vector_fma_issue. A behavioural FMA unit with
// fixed latency answers issued ops; expected writebacks (hand-computed
// per-lane values, 16 x 32-bit lanes) are queued when a request is
// accepted and a negedge monitor compares every writeback handshake.
module tb_vector_fma_issue;

   localparam int LAT = 5;

   typedef struct {
      logic [5:0]  tag;
      logic [31:0] lane;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [5:0]    req_tag_i;
   logic [511:0]  req_src1_i, req_src2_i, req_src3_i;
   logic          flush_i;
   logic          fma_valid_o;
   logic [511:0]  fma_src1_o, fma_src2_o, fma_src3_o;
   logic          fma_valid_i;
   logic [511:0]  fma_result_i;
   logic          wb_valid_o;
   logic          wb_ready_i;
   logic [5:0]    wb_tag_o;
   logic [511:0]  wb_data_o;
   logic          err_o;
`ifdef VFMA_ISSUE_PERF_EN
   logic [31:0]   perf_issued_o, perf_stall_o;
`endif

   int            total = 0;
   int            bad = 0;
   exp_t          sb[$];
   logic [5:0]    exp_tag;
   logic [31:0]   exp_lane;
   logic          kill_mode;
   logic          inject;

   logic [LAT-1:0] pv = '0;
   logic [511:0]   pd [LAT];

   logic          hold_v = 1'b0;
   logic [5:0]    hold_tag;
   logic [511:0]  hold_data;

   always #5 clk = ~clk;

   vector_fma_issue dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_tag_i    (req_tag_i),
      .req_src1_i   (req_src1_i),
      .req_src2_i   (req_src2_i),
      .req_src3_i   (req_src3_i),
      .flush_i      (flush_i),
      .fma_valid_o  (fma_valid_o),
      .fma_src1_o   (fma_src1_o),
      .fma_src2_o   (fma_src2_o),
      .fma_src3_o   (fma_src3_o),
      .fma_valid_i  (fma_valid_i),
      .fma_result_i (fma_result_i),
      .wb_valid_o   (wb_valid_o),
      .wb_ready_i   (wb_ready_i),
      .wb_tag_o     (wb_tag_o),
      .wb_data_o    (wb_data_o),
`ifdef VFMA_ISSUE_PERF_EN
      .perf_issued_o(perf_issued_o),
      .perf_stall_o (perf_stall_o),
`endif
      .err_o        (err_o)
   );

   // Behavioural FMA lanes: 16 x 32-bit a*b+c, modulo 2^32.
   function automatic logic [511:0] fma_calc(input logic [511:0] a, input logic [511:0] b,
                                             input logic [511:0] c);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i*32 +: 32] = a[i*32 +: 32] * b[i*32 +: 32] + c[i*32 +: 32];
      end
      return r;
   endfunction

   // Fixed-latency FMA unit: result appears LAT cycles after the issue strobe.
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], fma_valid_o};
      pd[0] <= fma_calc(fma_src1_o, fma_src2_o, fma_src3_o);
      for (int i = 1; i < LAT; i++) begin
         pd[i] <= pd[i-1];
      end
   end

   assign fma_valid_i  = pv[LAT-1] | inject;
   assign fma_result_i = pd[LAT-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Writeback monitor: order, tag, data, and hold-stable under stall.
   always @(negedge clk) begin
      if (rst !== 1'b0 || wb_valid_o !== 1'b1) begin
         hold_v <= 1'b0;
      end else begin
         if (hold_v) begin
            chk("wb_tag_stable", 32'(wb_tag_o), 32'(hold_tag));
            chkd("wb_data_stable", wb_data_o, hold_data);
         end
         if (wb_ready_i) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wb_unexpected: got tag %0h expected no writeback", wb_tag_o);
            end else begin
               chk("wb_tag", 32'(wb_tag_o), 32'(sb[0].tag));
               chkd("wb_data", wb_data_o, {16{sb[0].lane}});
               sb.delete(0);
            end
         end
         hold_v    <= ~wb_ready_i;
         hold_tag  <= wb_tag_o;
         hold_data <= wb_data_o;
      end
   end

   task automatic set_req(input logic [5:0] t, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] e);
      req_valid_i = 1'b1;
      req_tag_i   = t;
      req_src1_i  = {16{a}};
      req_src2_i  = {16{b}};
      req_src3_i  = {16{c}};
      exp_tag     = t;
      exp_lane    = e;
   endtask

   // One clock cycle: optional ready check, scoreboard push on accept.
   task automatic cyc(input string nm, input int rc);
      @(negedge clk);
      if (rc >= 0) begin
         chk(nm, 32'(req_ready_o), 32'(rc));
      end
      if (req_valid_i && req_ready_o && !kill_mode) begin
         sb.push_back('{exp_tag, exp_lane});
      end
      @(posedge clk);
      #1;
   endtask

   // Eight back-to-back accepts with writeback stalled.
   task automatic fill8(input logic [5:0] base);
      wb_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_req(6'(int'(base) + i), 32'(i + 1), 32'd2, 32'(i), 32'(3 * i + 2));
         cyc("fill_ready", 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      req_valid_i = 1'b0;
      req_tag_i   = '0;
      req_src1_i  = '0;
      req_src2_i  = '0;
      req_src3_i  = '0;
      flush_i     = 1'b0;
      wb_ready_i  = 1'b1;
      inject      = 1'b0;
      kill_mode   = 1'b0;
      exp_tag     = '0;
      exp_lane    = '0;

      // Reset state
      repeat (8) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ready_low", 32'(req_ready_o), 32'd0);
      chk("rst_fma_valid", 32'(fma_valid_o), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;

      // Single op: 2*3+4 = 10 per lane, issue at N+1, writeback at N+7
      set_req(6'h05, 32'd2, 32'd3, 32'd4, 32'd10);
      cyc("t1_ready", 1);
      req_valid_i = 1'b0;
      @(negedge clk);
      chk("t1_fma_valid", 32'(fma_valid_o), 32'd1);
      chkd("t1_src1", fma_src1_o, {16{32'd2}});
      chkd("t1_src2", fma_src2_o, {16{32'd3}});
      chkd("t1_src3", fma_src3_o, {16{32'd4}});
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         chk("t1_fma_valid_once", 32'(fma_valid_o), 32'd0);
         chk("t1_wb_valid_timing", 32'(wb_valid_o), (k == 7) ? 32'd1 : 32'd0);
      end
      @(posedge clk);
      #1;

      // Fill to capacity with writeback stalled, then pop/accept overlap
      fill8(6'h10);
      set_req(6'h18, 32'd10, 32'd10, 32'd5, 32'd105);
      cyc("full_ready_low", 0);
      repeat (8) cyc("full_hold", 0);
      wb_ready_i = 1'b1;
      cyc("ready_low_at_first_pop", 0);
      cyc("ready_back_after_pop", 1);
      set_req(6'h19, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'd1);
      wb_ready_i = 1'b0;
      cyc("ready_before_refill", 1);
      req_valid_i = 1'b0;
      wb_ready_i  = 1'b1;
      cyc("full_after_refill", 0);
      cyc("ready_after_pop_only", 1);
      repeat (16) cyc("", -1);

      // Flush: tags 1..4 are discarded, tag 9 (6*7+8 = 50) completes
      kill_mode = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_req(6'(i), 32'd1, 32'd1, 32'd1, 32'd2);
         cyc("flush_issue_ready", 1);
      end
      req_valid_i = 1'b0;
      cyc("", -1);
      flush_i = 1'b1;
      set_req(6'h09, 32'd6, 32'd7, 32'd8, 32'd50);
      cyc("ready_low_in_flush", 0);
      flush_i   = 1'b0;
      kill_mode = 1'b0;
      cyc("ready_after_flush", 1);
      req_valid_i = 1'b0;
      repeat (14) cyc("", -1);

      // All credits returned after flush: a full eight accepts fit again
      fill8(6'h30);
      req_valid_i = 1'b0;
      cyc("post_flush_full", 0);
      wb_ready_i = 1'b1;
      repeat (16) cyc("", -1);

      // Spurious result sets a sticky error, cleared only by reset
      @(negedge clk);
      chk("err_clear_before_inject", 32'(err_o), 32'd0);
      @(posedge clk);
      #1;
      inject = 1'b1;
      @(posedge clk);
      #1;
      inject = 1'b0;
      @(negedge clk);
      chk("err_set", 32'(err_o), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      chk("err_sticky", 32'(err_o), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared_by_rst", 32'(err_o), 32'd0);
      chk("ready_after_second_rst", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      #1;

`ifdef VFMA_ISSUE_PERF_EN
      // Four stalled cycles (flush holds ready low) then three accepts
      flush_i = 1'b1;
      set_req(6'h21, 32'd4, 32'd4, 32'd4, 32'd20);
      repeat (4) cyc("stall_ready_low", 0);
      flush_i = 1'b0;
      cyc("perf_accept", 1);
      set_req(6'h22, 32'd0, 32'd9, 32'd9, 32'd9);
      cyc("perf_accept", 1);
      set_req(6'h23, 32'd3, 32'd0, 32'd0, 32'd0);
      cyc("perf_accept", 1);
      req_valid_i = 1'b0;
      @(negedge clk);
      chk("perf_issued", perf_issued_o, 32'd3);
      chk("perf_stall", perf_stall_o, 32'd4);
      @(posedge clk);
      #1;
      repeat (12) cyc("", -1);
`endif

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vector_fma_issue.md
VECTOR_FMA_ISSUE -- requirements
Module: vector_fma_issue

Interface
REQ-001 SHALL have parameter LAT, default 5: fixed FMA pipeline latency, from fma_valid_o sampled to fma_valid_i.
REQ-002 SHALL have parameter TAG_W, default 6: width of the request tag.
REQ-003 SHALL have parameter RQ_DEPTH, default 8: result queue entries (power of two, 2..32).
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid_i  in  1  request valid.
REQ-007 req_ready_o  out  1  request accepted when valid&ready.
REQ-008 req_tag_i  in  TAG_W  request tag.
REQ-009 req_src1_i, req_src2_i, req_src3_i  in  512 each  operands a, b, c.
REQ-010 flush_i  in  1  discard all in-flight and queued work.
REQ-011 fma_valid_o  out  1  issue strobe to FMA unit.
REQ-012 fma_src1_o, fma_src2_o, fma_src3_o  out  512 each  registered operands.
REQ-013 fma_valid_i  in  1  FMA result valid.
REQ-014 fma_result_i  in  512  FMA result.
REQ-015 wb_valid_o  out  1  writeback valid.
REQ-016 wb_ready_i  in  1  writeback consumer ready.
REQ-017 wb_tag_o  out  TAG_W  tag of head result.
REQ-018 wb_data_o  out  512  head result data.
REQ-019 err_o  out  1  sticky protocol error.

Function
REQ-020 Accept at cycle N SHALL drive fma_valid_o=1 with captured operands at N+1; fma_valid_o SHALL be 0 in all other cycles.
REQ-021 Tag SHALL travel through a LAT-stage tag/valid/kill shift register aligned so the slot exits exactly when fma_valid_i for that op arrives (N+1+LAT).
REQ-022 Returning non-killed result SHALL be written into the FIFO with its tag; wb_valid_o SHALL rise no earlier than N+2+LAT (registered head; 7 cycles at default LAT).
REQ-023 Counter used (0..RQ_DEPTH) SHALL count ops in flight plus FIFO entries; +1 on accept, -1 on wb handshake, -1 on killed-result drop; simultaneous inc/dec leaves it unchanged.
REQ-024 req_ready_o SHALL be (used < RQ_DEPTH) & !flush_i & !rst, derived from registered state only, so FIFO never overflows (FMA unit has no backpressure).
REQ-025 wb_tag_o/wb_data_o SHALL hold stable while wb_valid_o=1 and wb_ready_i=0; results SHALL be returned in issue order.
REQ-026 FIFO pointers SHALL wrap modulo RQ_DEPTH; push and pop in the same cycle when full or empty-with-bypass-disallowed SHALL both complete correctly.
REQ-027 flush_i SHALL, in that cycle: empty the FIFO, set kill on all valid tag slots, block accept; used SHALL become the in-flight count, then drain as killed results return and are dropped.
REQ-028 err_o SHALL set and stay set on fma_valid_i=1 with exit tag slot invalid, or exit slot valid with fma_valid_i=0; cleared only by reset.

Reset
REQ-029 rst SHALL clear: req_ready_o-gating state, fma_valid_o=0, wb_valid_o=0, err_o=0, used=0, FIFO pointers, all tag slots invalid; operand/data registers need no reset.
REQ-030 rst asserted mid-operation SHALL abandon all work; results arriving after reset release with no valid slot SHALL set err_o.

Configuration
REQ-031 With VFMA_ISSUE_PERF_EN defined: SHALL add outputs perf_issued_o (32b, accepts) and perf_stall_o (32b, cycles req_valid_i=1 & req_ready_o=0), wrapping, cleared by rst and by no other event.
REQ-032 Without VFMA_ISSUE_PERF_EN: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package vfma_pkg SHALL hold VLEN=512, default LAT, tag width and the result-entry struct {tag, data}.
REQ-034 Result FIFO SHALL be sub-module vfma_result_fifo (parameterised depth, push/pop/full/empty).

Verification
REQ-035 Single op, tag 0x05, a=2, b=3, c=4 per lane, wb_ready_i=1 -> fma_valid_o at N+1, wb_valid_o at N+7, wb_tag_o=0x05, each lane 10.
REQ-036 Back-to-back 8 requests, wb_ready_i=0 -> req_ready_o drops after 8th accept, 8 results queued in order, none lost; raising wb_ready_i restores req_ready_o one cycle after first pop.
REQ-037 Full FIFO with accept and pop in same cycle -> used stays 8, req_ready_o stays low until pop-only cycle.
REQ-038 Issue tags 1..4, flush_i 2 cycles later -> no wb for tags 1..4, used returns to 0 by N+1+LAT, new tag 9 completes normally.
REQ-039 Inject fma_valid_i=1 with no op outstanding -> err_o=1 next cycle, stays 1 until rst.
REQ-040 With VFMA_ISSUE_PERF_EN: 3 accepts plus 4 stalled cycles -> perf_issued_o=3, perf_stall_o=4.
